// File: rtl/fft_pkg.sv
// Shared constants and types for the 256-point, 4-bank FFT sequencer.
// Holds the geometry, the FSM state encoding and the crossbar select codes.
package fft_pkg;

    localparam int N          = 256;
    localparam int LOG2N      = 8;
    localparam int ADDR_BIT   = 6;
    localparam int MEM_HEIGHT = 1 << ADDR_BIT;
    localparam int PIPE_LAT   = 3;

    localparam int AW   = 4 * ADDR_BIT;
    localparam int TW_W = LOG2N - 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN,
        UNLOAD,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        XBAR_CROSS  = 2'd0,
        XBAR_ADJ    = 2'd1,
        XBAR_BYPASS = 2'd2
    } xbar_t;

    // One write command travelling from the read side to the write side.
    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [1:0]    sel;
    } wr_cmd_t;

    function automatic logic [1:0] xbar_of(input logic [3:0] stg);
        logic [1:0] sel;
        if (stg == 4'd0)
            sel = XBAR_CROSS;
        else if (stg == 4'd1)
            sel = XBAR_ADJ;
        else
            sel = XBAR_BYPASS;
        return sel;
    endfunction

endpackage

// File: rtl/fft_ctrl_delay_line.sv
// Delays the read-side command {en, addr, xbar_sel} by PIPE_LAT cycles
// so butterfly results are written back in place.
// Ports: clk, rst (async active-low), din (read-side cmd), dout (write-side cmd).
module fft_ctrl_delay_line
    import fft_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  wr_cmd_t din,
    output wr_cmd_t dout
);

    wr_cmd_t pipe [PIPE_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_LAT; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < PIPE_LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[PIPE_LAT-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequencer for the 4-bank in-place FFT: LOAD, LOG2N compute stages with
// drain gaps, UNLOAD with backpressure, then a one-cycle done pulse.
// Ports: clk, rst (async active-low), start, in_valid, out_ready in;
// busy, done, prepare_data, rd_en, wr_en, addr_read, addr_write, m12, m13,
// bypass_en, tw_addr, stage, out_valid out.
module fft_seq_ctrl
    import fft_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done,
    output logic            prepare_data,
    output logic            rd_en,
    output logic            wr_en,
    output logic [AW-1:0]   addr_read,
    output logic [AW-1:0]   addr_write,
    output logic [1:0]      m12,
    output logic [1:0]      m13,
    output logic            bypass_en,
    output logic [TW_W-1:0] tw_addr,
    output logic [3:0]      stage,
    output logic            out_valid
);

    localparam logic [ADDR_BIT-1:0] CNT_MAX   = ADDR_BIT'(MEM_HEIGHT - 1);
    localparam logic [ADDR_BIT-1:0] DRAIN_MAX = ADDR_BIT'(PIPE_LAT - 1);
    localparam logic [3:0]          STG_MAX   = 4'(LOG2N - 1);

    state_t              state;
    logic [ADDR_BIT-1:0] cnt;
    logic [3:0]          stg;
    logic                rd_done;
    logic                ov;

    logic                in_cmp;
    logic                in_unl;
    logic [1:0]          xsel;
    logic [AW-1:0]       cnt_lanes;
    logic [ADDR_BIT+LOG2N-1:0] tw_full;
    wr_cmd_t             rd_cmd;
    wr_cmd_t             wr_cmd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            stg     <= '0;
            rd_done <= 1'b0;
            ov      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        cnt   <= '0;
                        stg   <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_MAX)
                            state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_MAX)
                        state <= DRAIN;
                end
                // cnt is reused to time the write-back drain.
                DRAIN: begin
                    if (cnt == DRAIN_MAX) begin
                        cnt <= '0;
                        if (stg == STG_MAX) begin
                            state   <= UNLOAD;
                            rd_done <= 1'b0;
                            ov      <= 1'b0;
                        end else begin
                            stg   <= stg + 4'd1;
                            state <= COMPUTE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // A read is only issued when the group in flight can move,
                // so the registered bank output is never overwritten.
                UNLOAD: begin
                    if (out_ready) begin
                        if (rd_done) begin
                            ov    <= 1'b0;
                            state <= DONE;
                        end else begin
                            ov  <= 1'b1;
                            cnt <= cnt + 1'b1;
                            if (cnt == CNT_MAX)
                                rd_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_cmp    = (state == COMPUTE);
    assign in_unl    = (state == UNLOAD);
    assign xsel      = xbar_of(stg);
    assign cnt_lanes = {4{cnt}};
    assign tw_full   = {{LOG2N{1'b0}}, cnt} << stg;

    // Only compute reads produce a write-back.
    assign rd_cmd.en   = in_cmp;
    assign rd_cmd.addr = in_cmp ? cnt_lanes : '0;
    assign rd_cmd.sel  = in_cmp ? xsel : 2'd0;

    fft_ctrl_delay_line u_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (rd_cmd),
        .dout (wr_cmd)
    );

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign prepare_data = (state == LOAD);
    assign rd_en        = in_cmp | (in_unl & out_ready & ~rd_done);
    assign addr_read    = (in_cmp | in_unl) ? cnt_lanes : '0;
    assign wr_en        = prepare_data ? in_valid : wr_cmd.en;
    assign addr_write   = prepare_data ? cnt_lanes : wr_cmd.addr;
    assign m12          = rd_cmd.sel;
    assign m13          = wr_cmd.sel;
    assign bypass_en    = in_cmp & (stg >= 4'd2);
    assign tw_addr      = in_cmp ? tw_full[TW_W-1:0] : '0;
    assign stage        = stg;
    assign out_valid    = ov;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl: scoreboarded load/unload groups,
// timed checks on stage boundaries, stalls and mid-run reset.
module tb_fft_seq_ctrl;
    import fft_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic            busy, done, prepare_data, rd_en, wr_en;
    logic [AW-1:0]   addr_read, addr_write;
    logic [1:0]      m12, m13;
    logic            bypass_en;
    logic [TW_W-1:0] tw_addr;
    logic [3:0]      stage;
    logic            out_valid;

    fft_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .prepare_data (prepare_data),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .addr_read    (addr_read),
        .addr_write   (addr_write),
        .m12          (m12),
        .m13          (m13),
        .bypass_en    (bypass_en),
        .tw_addr      (tw_addr),
        .stage        (stage),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input int v);
        logic [5:0] a;
        a = v[5:0];
        return {8'd0, a, a, a, a};
    endfunction

    int q_ld[$];
    int q_ul[$];
    int cs;
    bit mon_on = 0;
    bit tbl_on = 0;
    bit ls_mode = 0;
    bit us_mode = 0;
    int ul_r;
    int done_r;
    bit done_seen;
    int last_rd;

    task automatic tbl_checks(input int r);
        case (r)
            1: begin
                check("t1_prep", 32'(prepare_data), 32'd1);
                check("t1_busy", 32'(busy), 32'd1);
            end
            64: check("t64_prep", 32'(prepare_data), 32'd1);
            65: begin
                check("t65_prep", 32'(prepare_data), 32'd0);
                check("t65_rd", 32'(rd_en), 32'd1);
                check("t65_stage", 32'(stage), 32'd0);
                check("t65_m12", 32'(m12), 32'd0);
                check("t65_byp", 32'(bypass_en), 32'd0);
                check("t65_ra", 32'(addr_read), lanes(0));
            end
            68: begin
                check("t68_wr", 32'(wr_en), 32'd1);
                check("t68_wa", 32'(addr_write), lanes(0));
                check("t68_m13", 32'(m13), 32'd0);
            end
            128: begin
                check("t128_rd", 32'(rd_en), 32'd1);
                check("t128_ra", 32'(addr_read), lanes(63));
            end
            129, 130: check("drain_rd", 32'(rd_en), 32'd0);
            131: begin
                check("t131_rd", 32'(rd_en), 32'd0);
                check("t131_wr", 32'(wr_en), 32'd1);
                check("t131_wa", 32'(addr_write), lanes(63));
            end
            132: begin
                check("t132_rd", 32'(rd_en), 32'd1);
                check("t132_stage", 32'(stage), 32'd1);
                check("t132_m12", 32'(m12), 32'd1);
                check("t132_wr", 32'(wr_en), 32'd0);
            end
            135: begin
                check("t135_m13", 32'(m13), 32'd1);
                check("t135_wr", 32'(wr_en), 32'd1);
            end
            199: begin
                check("t199_stage", 32'(stage), 32'd2);
                check("t199_m12", 32'(m12), 32'd2);
                check("t199_byp", 32'(bypass_en), 32'd1);
            end
            202: check("t202_m13", 32'(m13), 32'd2);
            204: begin
                check("tw_s2c5", 32'(tw_addr), 32'd20);
                check("t204_ra", 32'(addr_read), lanes(5));
            end
            544: begin
                check("t544_stage", 32'(stage), 32'd7);
                check("tw_s7", 32'(tw_addr), 32'd0);
            end
            601: begin
                check("t601_rd", 32'(rd_en), 32'd1);
                check("t601_ov", 32'(out_valid), 32'd0);
                check("t601_ra", 32'(addr_read), lanes(0));
            end
            602: check("t602_ov", 32'(out_valid), 32'd1);
            666: check("t666_done", 32'(done), 32'd1);
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        int r;
        if (mon_on) begin
            r = cyc - cs;
            if (prepare_data && wr_en) begin
                check("ld_q", 32'(q_ld.size() > 0), 32'd1);
                if (q_ld.size() > 0)
                    check("ld_addr", 32'(addr_write), lanes(q_ld.pop_front()));
            end
            if (out_valid && out_ready) begin
                check("ul_q", 32'(q_ul.size() > 0), 32'd1);
                if (q_ul.size() > 0)
                    check("ul_addr", 32'(last_rd), 32'(q_ul.pop_front()));
            end
            if (rd_en && r >= ul_r)
                last_rd = int'(addr_read[ADDR_BIT-1:0]);
            if (done && !done_seen) begin
                done_seen = 1;
                done_r = r;
            end
            if (tbl_on)
                tbl_checks(r);
            if (ls_mode && r == 13) begin
                check("ls_wr", 32'(wr_en), 32'd0);
                check("ls_wa", 32'(addr_write), lanes(10));
                check("ls_prep", 32'(prepare_data), 32'd1);
            end
            if (ls_mode && r == 16)
                check("ls_resume", 32'(addr_write), lanes(10));
            if (us_mode && r == 632) begin
                check("us_ra", 32'(addr_read), lanes(30));
                check("us_ov", 32'(out_valid), 32'd1);
                check("us_rd", 32'(rd_en), 32'd0);
            end
        end
    end

    task automatic run(input bit ls, input bit us, input bit sp,
                       input int exp_done);
        int r;
        q_ld.delete();
        q_ul.delete();
        for (int i = 0; i < MEM_HEIGHT; i++) begin
            q_ld.push_back(i);
            q_ul.push_back(i);
        end
        ls_mode = ls;
        us_mode = us;
        tbl_on = !ls && !us;
        ul_r = 601 + (ls ? 5 : 0);
        done_seen = 0;
        done_r = -1;
        last_rd = -1;
        @(posedge clk); #1;
        start = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        cs = cyc - 1;
        start = 1'b0;
        mon_on = 1;
        for (int k = 0; k < 1000 && !done_seen; k++) begin
            @(posedge clk); #1;
            r = cyc - cs;
            in_valid = !(ls && r >= 11 && r <= 15);
            out_ready = !(us && r >= 631 && r <= 634);
            start = sp && (r == 100);
        end
        mon_on = 0;
        start = 1'b0;
        check("done_cycle", 32'(done_r), 32'(exp_done));
        check("ld_left", 32'(q_ld.size()), 32'd0);
        check("ul_left", 32'(q_ul.size()), 32'd0);
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        check(tag, 32'({busy, done, prepare_data, rd_en, wr_en, m12, m13,
                        bypass_en, tw_addr, stage, out_valid}), 32'd0);
        check({tag, "_ra"}, 32'(addr_read), 32'd0);
        check({tag, "_wa"}, 32'(addr_write), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("rst_init");
        @(posedge clk); #1;
        rst = 1'b1;

        run(0, 0, 0, 666);
        run(1, 0, 0, 671);
        run(0, 1, 0, 670);

        // Abort in stage 3, with start held during reset.
        @(posedge clk); #1;
        start = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (275) @(posedge clk);
        #1;
        check("pre_rst_stage", 32'(stage), 32'd3);
        rst = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_zero("rst_mid");
        end
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_stage", 32'(stage), 32'd0);

        run(0, 0, 1, 666);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
